// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key event controller
package ps2_pkg;

  // Frame capture FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes folded into the following key event
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // One buffered key event
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous event FIFO of ps2_evt_t entries
//
// Ports:
//   clk_i, rst_i      system clock, asynchronous active-high reset
//   push_i/push_data_i  write request and entry
//   pop_i             read request (ignored when empty)
//   head_o            oldest entry; all zeros when empty
//   full_o, empty_o   occupancy flags
//
// A push while full succeeds only when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  ps2_evt_t push_data_i,
  input  logic     pop_i,
  output ps2_evt_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] wr_q, rd_q;
  ps2_evt_t    mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 keyboard frame capture, prefix folding and event buffering
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   PS2_clock, PS2_data   raw PS/2 pins, asynchronous to clock
//   evt_valid/evt_ready   event FIFO handshake, pop on valid && ready
//   evt_code/break/ext    head event (zero when empty)
//   frame_err             1-cycle pulse on bad start/parity/stop or timeout
//   overflow              1-cycle pulse when an event is dropped on a full FIFO
//
// Optional feature macro: PS2_TIMEOUT_EN builds a mid-frame idle timeout of
// TIMEOUT_CYC cycles; without it a stalled frame waits for further edges.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2_clock,
  input  logic       PS2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       frame_err,
  output logic       overflow
);

  // Pin synchronizers; clk_prev_q gives the falling-edge detector
  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic ps2d_s1_q, ps2d_s2_q;
  logic sample;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2c_s1_q   <= 1'b0;
      ps2c_s2_q   <= 1'b0;
      ps2c_prev_q <= 1'b0;
      ps2d_s1_q   <= 1'b0;
      ps2d_s2_q   <= 1'b0;
    end else begin
      ps2c_s1_q   <= PS2_clock;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= PS2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign sample = ps2c_prev_q & ~ps2c_s2_q;

  // Frame FSM state
  ps2_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       byte_ok_q, byte_ok_d;
  logic       frame_err_q, frame_err_d;
  logic       tmo_hit;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q;

  assign tmo_hit = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               to_cnt_q <= '0;
    else if (sample || state_q == IDLE || tmo_hit) to_cnt_q <= '0;
    else                                     to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    byte_ok_d   = 1'b0;
    frame_err_d = 1'b0;
    if (sample) begin
      unique case (state_q)
        IDLE: begin
          if (!ps2d_s2_q) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {ps2d_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = ps2d_s2_q;
          state_d = STOP;
        end
        STOP: begin
          // Odd parity over data plus parity bit, stop bit must be high
          if (ps2d_s2_q && (^{shreg_q, par_q})) byte_ok_d = 1'b1;
          else                                  frame_err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      byte_ok_q   <= byte_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Prefix decoder: shreg_q stays stable during the byte_ok_q cycle
  logic     ext_pend_q, ext_pend_d;
  logic     brk_pend_q, brk_pend_d;
  logic     evt_push, evt_pop;
  logic     fifo_full, fifo_empty;
  logic     overflow_q, overflow_d;
  ps2_evt_t push_evt, head_evt;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    evt_push   = 1'b0;
    push_evt   = '{code: shreg_q, brk: brk_pend_q, ext: ext_pend_q};
    if (frame_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_ok_q) begin
      if (shreg_q == PS2_PFX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == PS2_PFX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        evt_push   = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  assign evt_pop    = evt_valid && evt_ready;
  assign overflow_d = evt_push && fifo_full && !evt_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (evt_push),
    .push_data_i (push_evt),
    .pop_i       (evt_pop),
    .head_o      (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_break = head_evt.brk;
  assign evt_ext   = head_evt.ext;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - self-checking bench for ps2_key_event_ctrl
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 300;
  localparam int HALF  = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_clock = 1'b1;
  logic       PS2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_break, evt_ext, frame_err, overflow;
  logic [7:0] evt_code;

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .PS2_clock (PS2_clock),
    .PS2_data  (PS2_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  always @(negedge clock) begin
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
  end

  // Reference model: decoded events as {code, brk, ext}, pending prefixes, pulse totals
  logic [9:0] exp_q[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  int         m_ferr_tot = 0;
  int         m_ovf_tot = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr_tot++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({b, m_brk, m_ext});
      else m_ovf_tot++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ bad_par;
    bits[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      PS2_data = bits[i];
      tick(HALF);
      PS2_clock = 1'b0;
      tick(HALF);
      PS2_clock = 1'b1;
    end
    if (nbits == 11) begin
      PS2_data = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_frame(b, bad_par, 11);
    model_byte(b, !bad_par);
  endtask

  // Pops one event if available within a bounded window; no checking here
  task automatic pop_event(output logic [9:0] ev, output bit got);
    got = 1'b0;
    ev  = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (evt_valid) begin
        ev = {evt_code, evt_break, evt_ext};
        got = 1'b1;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
      end else begin
        tick(1);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] ev;
    bit got;
    do_reset();
    n_cmp++;
    if ({evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0", {evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow});
    end
    pop_event(ev, got);
    n_cmp++;
    if (got !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_empty: got event %h expected none", ev);
    end
  endtask

  task automatic test_make();
    logic [9:0] ev;
    bit got;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 10);
    PS2_data = 1'b1;
    tick(HALF);
    PS2_clock = 1'b0;
    tick(3);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL make_latency_early: got valid %b expected 0", evt_valid);
    end
    tick(1);
    n_cmp++;
    if (evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL make_latency: got valid %b expected 1", evt_valid);
    end
    tick(HALF - 4);
    PS2_clock = 1'b1;
    tick(HALF);
    model_byte(8'h1C, 1'b1);
    pop_event(ev, got);
    n_cmp++;
    if (!got || ev !== exp_q[0]) begin
      n_bad++;
      $display("FAIL make_event: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
    end
    void'(exp_q.pop_front());
    n_cmp++;
    if (ferr_cnt != f0) begin
      n_bad++;
      $display("FAIL make_no_ferr: got %0d pulses expected 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_break();
    logic [9:0] ev;
    bit got;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    n_cmp++;
    if (exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL break_model_depth: got %0d expected 1", exp_q.size());
    end
    while (exp_q.size() > 0) begin
      pop_event(ev, got);
      n_cmp++;
      if (!got || ev !== exp_q[0]) begin
        n_bad++;
        $display("FAIL break_event: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    tick(2);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL break_single: got valid %b expected 0", evt_valid);
    end
  endtask

  task automatic test_ext_break();
    logic [9:0] ev;
    bit got;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'h1C, 1'b0);
    while (exp_q.size() > 0) begin
      pop_event(ev, got);
      n_cmp++;
      if (!got || ev !== exp_q[0]) begin
        n_bad++;
        $display("FAIL ext_break_event: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (evt_valid !== 1'b0 || evt_code !== 8'h00) begin
      n_bad++;
      $display("FAIL ext_break_empty: got valid %b code %h expected 0 00", evt_valid, evt_code);
    end
  endtask

  task automatic test_parity_err();
    logic [9:0] ev;
    bit got;
    send_byte(8'h1C, 1'b1);
    tick(4);
    n_cmp++;
    if (ferr_cnt != m_ferr_tot) begin
      n_bad++;
      $display("FAIL parity_ferr: got %0d pulses expected %0d", ferr_cnt, m_ferr_tot);
    end
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_no_event: got valid %b expected 0", evt_valid);
    end
    send_byte(8'h1B, 1'b0);
    pop_event(ev, got);
    n_cmp++;
    if (!got || ev !== exp_q[0]) begin
      n_bad++;
      $display("FAIL parity_recover: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    logic [9:0] ev;
    bit got;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
    n_cmp++;
    if (ovf_cnt != m_ovf_tot) begin
      n_bad++;
      $display("FAIL ovf_early: got %0d pulses expected %0d", ovf_cnt, m_ovf_tot);
    end
    send_byte(codes[4], 1'b0);
    n_cmp++;
    if (ovf_cnt != m_ovf_tot) begin
      n_bad++;
      $display("FAIL ovf_fifth: got %0d pulses expected %0d", ovf_cnt, m_ovf_tot);
    end
    tick(5);
    n_cmp++;
    if (evt_valid !== 1'b1 || {evt_code, evt_break, evt_ext} !== exp_q[0]) begin
      n_bad++;
      $display("FAIL ovf_hold: got %h expected %h", {evt_code, evt_break, evt_ext}, exp_q[0]);
    end
    while (exp_q.size() > 0) begin
      pop_event(ev, got);
      n_cmp++;
      if (!got || ev !== exp_q[0]) begin
        n_bad++;
        $display("FAIL ovf_drain: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_empty: got valid %b expected 0", evt_valid);
    end
  endtask

  task automatic test_random();
    logic [9:0] ev;
    bit got;
    logic [7:0] b;
    int r, n;
    for (int round = 0; round < 6; round++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 5);
        if (r == 0)      b = 8'hE0;
        else if (r == 1) b = 8'hF0;
        else             b = 8'($urandom_range(0, 255));
        send_byte(b, ($urandom_range(0, 7) == 0));
      end
      tick(4);
      n_cmp++;
      if (ferr_cnt != m_ferr_tot || ovf_cnt != m_ovf_tot) begin
        n_bad++;
        $display("FAIL random_pulses: got ferr %0d ovf %0d expected ferr %0d ovf %0d", ferr_cnt, ovf_cnt, m_ferr_tot, m_ovf_tot);
      end
      while (exp_q.size() > 0) begin
        pop_event(ev, got);
        n_cmp++;
        if (!got || ev !== exp_q[0]) begin
          n_bad++;
          $display("FAIL random_event: got %h (valid %0d) expected %h", ev, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL random_empty: got valid %b expected 0", evt_valid);
      end
    end
  endtask

  task automatic test_timeout();
    logic [9:0] ev;
    bit got;
    send_byte(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0, 5);
    PS2_data = 1'b1;
    tick(TMO + 20);
`ifdef PS2_TIMEOUT_EN
    m_ferr_tot++;
    m_ext = 1'b0;
    m_brk = 1'b0;
`endif
    n_cmp++;
    if (ferr_cnt != m_ferr_tot) begin
      n_bad++;
      $display("FAIL timeout_ferr: got %0d pulses expected %0d", ferr_cnt, m_ferr_tot);
    end
`ifndef PS2_TIMEOUT_EN
    do_reset();
`endif
    send_byte(8'h1C, 1'b0);
    pop_event(ev, got);
    n_cmp++;
    if (!got || ev !== 10'({8'h1C, 2'b00})) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h (valid %0d) expected %h", ev, got, 10'({8'h1C, 2'b00}));
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity_err();
    test_overflow();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
